adder_sequencer: RTL and testbench

ADDER_SEQUENCER -- requirements
Module: adder_sequencer

---
 rtl/adder_seq_pkg.sv | 23 ++
 rtl/adder_parallel_4_bit.sv | 31 +++
 rtl/adder_sequencer.sv | 159 +++++++++++++++
 tb/tb_adder_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_seq_pkg
// Description : Shared constants for the nibble-serial adder sequencer:
//               nibble width, FSM state encoding and one-hot grant codes.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_REQ0 = 2'b01;
    localparam logic [1:0] GNT_REQ1 = 2'b10;

endpackage : adder_seq_pkg
`default_nettype wire

// File: rtl/adder_parallel_4_bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_parallel_4_bit
// Description : 4-bit ripple-carry adder, one nibble per call of the shared
//               datapath in adder_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_parallel_4_bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    // One full adder per bit, carry rippling from bit 0 upward
    generate
        for (genvar g = 0; g < 4; g++) begin : g_bit
            assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[4];

endmodule : adder_parallel_4_bit
`default_nettype wire

// File: rtl/adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adder_sequencer
// Description : Two-requester, round-robin arbitrated WIDTH-bit adder built on
//               one shared 4-bit adder, processing one nibble per cycle LSB
//               first. Optional macro ADDER_SEQUENCER_OVERFLOW_EN adds a
//               two's-complement overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16      // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] num1_0,
    input  logic [WIDTH-1:0] num2_0,
    input  logic [WIDTH-1:0] num1_1,
    input  logic [WIDTH-1:0] num2_1,
    input  logic             incarry_0,
    input  logic             incarry_1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef ADDER_SEQUENCER_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             outcarry
);

    localparam int                STEPS      = WIDTH / NIBBLE;
    localparam int                CNT_W      = $clog2(STEPS) + 1;
    localparam logic [CNT_W-1:0]  c_LAST_CNT = CNT_W'(STEPS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_grant;
    logic               r_ptr;       // preferred requester on a tie

    logic               w_start;
    logic               w_win;       // 0 = requester 0, 1 = requester 1
    logic               w_last;
    logic [NIBBLE-1:0]  w_nib_sum;
    logic               w_nib_cout;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state, arbitration and last-nibble decode
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_win        = r_ptr;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_start      = 1'b1;
                    w_next_state = RUN;
                    // On a tie the pointer decides; otherwise the lone requester
                    w_win        = (req0 && req1) ? r_ptr : req1;
                end
            end
            RUN: begin
                w_last = (r_cnt == c_LAST_CNT);
                if (w_last) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, round-robin pointer and nibble counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= GNT_NONE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_start) begin
            r_grant <= w_win ? GNT_REQ1 : GNT_REQ0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end else if (r_state == DONE) begin
            r_grant <= GNT_NONE;
            // Hand preference to whoever was not just served
            r_ptr   <= r_grant[0];
        end
    end

    adder_parallel_4_bit u_nibble_adder (
        .i_a    (r_a[NIBBLE-1:0]),
        .i_b    (r_b[NIBBLE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // Operand shift registers, sum assembly and carry chain across nibbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_start) begin
            r_a     <= w_win ? num1_1    : num1_0;
            r_b     <= w_win ? num2_1    : num2_0;
            r_carry <= w_win ? incarry_1 : incarry_0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> NIBBLE;
            r_b     <= r_b >> NIBBLE;
            r_sum   <= {w_nib_sum, r_sum[WIDTH-1:NIBBLE]};
            r_carry <= w_nib_cout;
        end
    end

`ifdef ADDER_SEQUENCER_OVERFLOW_EN
    logic r_msb_a;
    logic r_msb_b;
    logic r_ovf;

    // Operand sign bits shift out early, so keep them for the final nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msb_a <= 1'b0;
            r_msb_b <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_start) begin
            r_msb_a <= w_win ? num1_1[WIDTH-1] : num1_0[WIDTH-1];
            r_msb_b <= w_win ? num2_1[WIDTH-1] : num2_0[WIDTH-1];
        end else if (w_last) begin
            r_ovf   <= (r_msb_a == r_msb_b) && (w_nib_sum[NIBBLE-1] != r_msb_a);
        end
    end

    assign overflow = r_ovf;
`endif

    assign grant    = r_grant;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign sum      = r_sum;
    assign outcarry = r_carry;

endmodule : adder_sequencer
`default_nettype wire

// File: tb/tb_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_sequencer
// Description : Scoreboard bench for adder_sequencer (WIDTH=16). Expected
//               results are queued when a request is driven and compared when
//               done pulses. Honours ADDER_SEQUENCER_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] num1_0, num2_0, num1_1, num2_1;
    logic             incarry_0, incarry_1;
    logic [1:0]       grant;
    logic             busy, done, outcarry;
    logic [WIDTH-1:0] sum;
`ifdef ADDER_SEQUENCER_OVERFLOW_EN
    logic             overflow;
`endif

    adder_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .num1_0    (num1_0),
        .num2_0    (num2_0),
        .num1_1    (num1_1),
        .num2_1    (num2_1),
        .incarry_0 (incarry_0),
        .incarry_1 (incarry_1),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
`ifdef ADDER_SEQUENCER_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .outcarry  (outcarry)
    );

    typedef struct {
        logic [1:0]       gnt;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             ovf;
        int               done_cyc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: plain 17-bit addition
    function automatic exp_t model(input logic [1:0] g, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin, input int dc);
        exp_t       e;
        logic [WIDTH:0] full;
        full       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.gnt      = g;
        e.s        = full[WIDTH-1:0];
        e.c        = full[WIDTH];
        e.ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        e.done_cyc = dc;
        return e;
    endfunction

    // Output monitor: every done pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("grant",    32'(grant),    32'(e.gnt));
                check("sum",      32'(sum),      32'(e.s));
                check("outcarry", 32'(outcarry), 32'(e.c));
                check("latency",  32'(cyc),      32'(e.done_cyc));
`ifdef ADDER_SEQUENCER_OVERFLOW_EN
                check("overflow", 32'(overflow), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) break;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (q.size() != 0) begin
            check("timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic drive(input int who, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
        if (who == 0) begin
            num1_0 = a; num2_0 = b; incarry_0 = cin; req0 = 1'b1;
        end else begin
            num1_1 = a; num2_1 = b; incarry_1 = cin; req1 = 1'b1;
        end
    endtask

    // Single-requester add; optionally disturb operands and drop req at start+1
    task automatic run_single(input int who, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic cin, input bit disturb);
        @(negedge clk);
        drive(who, a, b, cin);
        q.push_back(model(who == 0 ? 2'b01 : 2'b10, a, b, cin, cyc + 5));
        if (disturb) begin
            @(posedge clk);
            @(posedge clk);
            #2;
            num1_0 = ~a; num2_0 = ~b; incarry_0 = ~cin;
            num1_1 = ~a; num2_1 = ~b; incarry_1 = ~cin;
            req0 = 1'b0; req1 = 1'b0;
        end
        wait_drain(20);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        num1_0 = '0; num2_0 = '0; num1_1 = '0; num2_1 = '0;
        incarry_0 = 1'b0; incarry_1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_sum",      32'(sum),      32'd0);
        check("rst_outcarry", 32'(outcarry), 32'd0);
`ifdef ADDER_SEQUENCER_OVERFLOW_EN
        check("rst_overflow", 32'(overflow), 32'd0);
`endif
        rst = 1'b0;

        // Basic adds from each requester
        run_single(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("hold_sum",  32'(sum),      32'h0000);
        check("hold_cout", 32'(outcarry), 32'd1);
        check("idle_busy", 32'(busy),     32'd0);
        run_single(1, 16'h1234, 16'h4321, 1'b1, 1'b0);

        // Reset two edges into an add: no done, everything cleared
        @(negedge clk);
        drive(0, 16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_grant", 32'(grant), 32'h1);
        check("mid_busy",  32'(busy),  32'd1);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        check("arst_grant",    32'(grant),    32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_done",     32'(done),     32'd0);
        check("arst_sum",      32'(sum),      32'd0);
        check("arst_outcarry", 32'(outcarry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run_single(1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);

        // Both held: pointer starts at requester 0, grants alternate
        @(negedge clk);
        drive(0, 16'h1111, 16'h2222, 1'b0);
        drive(1, 16'h8000, 16'h8000, 1'b1);
        q.push_back(model(2'b01, 16'h1111, 16'h2222, 1'b0, cyc + 5));
        q.push_back(model(2'b10, 16'h8000, 16'h8000, 1'b1, cyc + 11));
        q.push_back(model(2'b01, 16'h1111, 16'h2222, 1'b0, cyc + 17));
        wait_drain(40);

        // Operands changed and req dropped right after start
        run_single(0, 16'hAAAA, 16'h5555, 1'b1, 1'b1);

        // Signed overflow case
        run_single(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);

        // Random single-requester traffic
        for (int k = 0; k < 6; k++) begin
            run_single(k % 2, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1)), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule : tb_adder_sequencer
`default_nettype wire
